// File: rtl/tc0100scn_pkg.sv
// Shared definitions for the TC0100SCN ROM-channel responder.
package tc0100scn_pkg;

  // Width of the tilemap chip's rom_address bus.
  localparam int ROM_AW = 21;

  // Fetch sequencer states: wait for a request, read the low half, read the high half.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2
  } rom_state_t;

endpackage

// File: rtl/tc0100scn_rom_responder.sv
// TC0100SCN ROM responder: services the chip's toggle-handshake 32-bit
// tile-row fetch by issuing two 16-bit reads on the shared SDRAM port.
// Optional build macro TC0100SCN_ROM_CACHE_EN adds a single-entry
// last-word cache that answers a repeated address in one cycle.
module tc0100scn_rom_responder
  import tc0100scn_pkg::*;
#(
  parameter int                MEM_AW    = 26,
  parameter logic [MEM_AW-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROM_AW-1:0] rom_address,
  input  logic              rom_req,
  output logic              rom_ack,
  output logic [31:0]       rom_data,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [15:0]       mem_data
);

  rom_state_t        state_q, state_d;
  logic [MEM_AW-1:0] ea_q, ea_d;
  logic [15:0]       lo_q, lo_d;
  logic [31:0]       rom_data_q, rom_data_d;
  logic              rom_ack_q, rom_ack_d;
  logic              mem_rd_q, mem_rd_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;

  logic              pending;
  logic              ready_ok;
  logic [MEM_AW-1:0] req_ea;
  logic              unused_addr_lsbs;

  // The word address ignores the byte-lane bits; the sum wraps within MEM_AW.
  assign req_ea           = BASE_ADDR + MEM_AW'({rom_address[ROM_AW-1:2], 2'b00});
  assign unused_addr_lsbs = ^rom_address[1:0];
  assign pending          = (rom_req != rom_ack_q);
  // A ready pulse only counts while a read is actually outstanding.
  assign ready_ok         = mem_ready && mem_rd_q;

`ifdef TC0100SCN_ROM_CACHE_EN
  logic              c_valid_q, c_valid_d;
  logic [MEM_AW-1:0] c_tag_q, c_tag_d;
  logic [31:0]       c_data_q, c_data_d;
  logic              cache_hit;

  assign cache_hit = c_valid_q && (c_tag_q == req_ea);
`endif

  // Next-state and output decode for the fetch sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    ea_d       = ea_q;
    lo_d       = lo_q;
    rom_data_d = rom_data_q;
    rom_ack_d  = rom_ack_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
`ifdef TC0100SCN_ROM_CACHE_EN
    c_valid_d  = c_valid_q;
    c_tag_d    = c_tag_q;
    c_data_d   = c_data_q;
`endif

    case (state_q)
      IDLE: begin
        mem_rd_d = 1'b0;
        if (pending) begin
          ea_d = req_ea;
`ifdef TC0100SCN_ROM_CACHE_EN
          if (cache_hit) begin
            rom_data_d = c_data_q;
            rom_ack_d  = ~rom_ack_q;
          end else begin
            state_d    = RD_LO;
            mem_rd_d   = 1'b1;
            mem_addr_d = req_ea;
          end
`else
          state_d    = RD_LO;
          mem_rd_d   = 1'b1;
          mem_addr_d = req_ea;
`endif
        end
      end

      RD_LO: begin
        if (ready_ok) begin
          lo_d       = mem_data;
          mem_addr_d = ea_q + MEM_AW'(2);
          state_d    = RD_HI;
        end
      end

      RD_HI: begin
        if (ready_ok) begin
          rom_data_d = {mem_data, lo_q};
          rom_ack_d  = ~rom_ack_q;
          mem_rd_d   = 1'b0;
          state_d    = IDLE;
`ifdef TC0100SCN_ROM_CACHE_EN
          c_valid_d  = 1'b1;
          c_tag_d    = ea_q;
          c_data_d   = {mem_data, lo_q};
`endif
        end
      end

      default: begin
        state_d  = IDLE;
        mem_rd_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; an in-flight fetch is dropped.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q    <= IDLE;
      ea_q       <= '0;
      lo_q       <= '0;
      rom_data_q <= '0;
      rom_ack_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
`ifdef TC0100SCN_ROM_CACHE_EN
      // NOTE: only the valid bit matters for correctness; tag/data are cleared for clean waveforms.
      c_valid_q  <= 1'b0;
      c_tag_q    <= '0;
      c_data_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ea_q       <= ea_d;
      lo_q       <= lo_d;
      rom_data_q <= rom_data_d;
      rom_ack_q  <= rom_ack_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
`ifdef TC0100SCN_ROM_CACHE_EN
      c_valid_q  <= c_valid_d;
      c_tag_q    <= c_tag_d;
      c_data_q   <= c_data_d;
`endif
    end
  end

  assign rom_ack  = rom_ack_q;
  assign rom_data = rom_data_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_tc0100scn_rom_responder.sv
// Self-checking bench for tc0100scn_rom_responder: a wait-state memory
// model, a stability monitor and a transaction-level reference model.
module tb_tc0100scn_rom_responder;

  localparam logic [25:0] TB_BASE   = 26'h200000;
  localparam int          LAT_LIMIT = 300;
`ifdef TC0100SCN_ROM_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] rom_address;
  logic        rom_req;
  logic        rom_ack;
  logic [31:0] rom_data;
  logic [25:0] mem_addr;
  logic        mem_rd;
  logic        mem_ready;
  logic [15:0] mem_data;

  int checks   = 0;
  int failures = 0;

  tc0100scn_rom_responder #(.MEM_AW(26), .BASE_ADDR(TB_BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .rom_address(rom_address),
    .rom_req    (rom_req),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_ready  (mem_ready),
    .mem_data   (mem_data)
  );

  always #5 clk = ~clk;

  // ---------------- memory contents ----------------
  logic [15:0] mem_init [logic [25:0]];

  function automatic logic [15:0] mem_word(input logic [25:0] a);
    if (mem_init.exists(a)) return mem_init[a];
    return 16'((longint'(a) * 40503) >> 5) ^ 16'h1F2E;
  endfunction

  // ---------------- reference model ----------------
  bit          exp_ack;
  bit          c_valid;
  logic [25:0] c_tag;

  function automatic logic [25:0] exp_ea(input logic [20:0] a);
    longint s;
    s = longint'(TB_BASE) + longint'(a) - longint'(a % 4);
    return 26'(s % 67108864);
  endfunction

  function automatic logic [31:0] exp_word(input logic [25:0] ea);
    logic [25:0] hi;
    hi = ea + 26'd2;
    return {mem_word(hi), mem_word(ea)};
  endfunction

  function automatic bit predict_hit(input logic [25:0] ea);
    return CACHE_EN && c_valid && (c_tag == ea);
  endfunction

  // ---------------- memory responder model ----------------
  bit          model_en = 1'b1;
  bit          active   = 1'b0;
  int          cnt      = 0;
  int          mem_wait = 0;
  logic [25:0] rd_log [$];

  always @(posedge clk) begin
    #1;
    if (model_en) begin
      if (mem_ready) active = 1'b0;
      mem_ready = 1'b0;
      if (mem_rd === 1'b1) begin
        if (!active) begin
          active = 1'b1;
          cnt    = 0;
        end else begin
          cnt++;
        end
        if (cnt >= mem_wait) begin
          mem_ready = 1'b1;
          mem_data  = mem_word(mem_addr);
          rd_log.push_back(mem_addr);
        end
      end else begin
        active = 1'b0;
      end
    end
  end

  // ---------------- stability monitor ----------------
  int          stab_err = 0;
  bit          mon_armed = 1'b0;
  logic [31:0] p_data;
  logic        p_ack, p_rd, p_ready, p_reset;
  logic [25:0] p_addr;

  always @(negedge clk) begin
    if (mon_armed && !reset && !p_reset) begin
      if (rom_data !== p_data && rom_ack === p_ack) stab_err++;
      if (p_rd && !p_ready && (mem_rd !== 1'b1 || mem_addr !== p_addr)) stab_err++;
    end
    p_data    = rom_data;
    p_ack     = rom_ack;
    p_rd      = mem_rd;
    p_ready   = mem_ready;
    p_addr    = mem_addr;
    p_reset   = reset;
    mon_armed = 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic run_fetch(input logic [20:0] addr, input int wcyc,
                           input bit immediate, input bit scramble, output int lat);
    logic ack0;
    if (!immediate) @(negedge clk);
    mem_wait = wcyc;
    rd_log.delete();
    ack0        = rom_ack;
    rom_address = addr;
    rom_req     = ~rom_req;
    lat = 0;
    while (rom_ack === ack0 && lat < LAT_LIMIT) begin
      @(negedge clk);
      lat++;
      if (scramble) rom_address = 21'($urandom);
    end
    if (rom_ack === ack0) lat = -1;
  endtask

  task automatic score_fetch(input string name, input logic [20:0] addr,
                             input int wcyc, input int lat, input int stab0);
    logic [25:0] ea;
    bit          hit;
    int          exp_lat;
    bit          reads_ok;
    ea      = exp_ea(addr);
    hit     = predict_hit(ea);
    exp_lat = hit ? 1 : 3 + 2 * wcyc;
    exp_ack = ~exp_ack;

    checks++;
    if (lat !== exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (rom_data !== exp_word(ea)) begin
      failures++;
      $display("FAIL %s rom_data: got %h expected %h", name, rom_data, exp_word(ea));
    end
    checks++;
    if (rom_ack !== exp_ack) begin
      failures++;
      $display("FAIL %s rom_ack: got %b expected %b", name, rom_ack, exp_ack);
    end
    reads_ok = hit ? (rd_log.size() == 0)
                   : (rd_log.size() == 2 && rd_log[0] == ea && rd_log[1] == ea + 26'd2);
    checks++;
    if (!reads_ok) begin
      failures++;
      $display("FAIL %s mem reads: got %0d reads (first %h) expected %0d reads at %h", name,
               rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 26'h0, hit ? 0 : 2, ea);
    end
    checks++;
    if (stab_err !== stab0) begin
      failures++;
      $display("FAIL %s stability: got %0d violations expected 0", name, stab_err - stab0);
    end
    if (CACHE_EN) begin
      c_valid = 1'b1;
      c_tag   = ea;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset       = 1'b1;
    rom_req     = 1'b0;
    rom_address = '0;
    mem_ready   = 1'b0;
    mem_data    = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (rom_ack !== 1'b0) begin failures++; $display("FAIL reset rom_ack: got %b expected 0", rom_ack); end
    checks++;
    if (rom_data !== 32'h0) begin failures++; $display("FAIL reset rom_data: got %h expected 0", rom_data); end
    checks++;
    if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset mem_rd: got %b expected 0", mem_rd); end
    checks++;
    if (mem_addr !== 26'h0) begin failures++; $display("FAIL reset mem_addr: got %h expected 0", mem_addr); end
    reset   = 1'b0;
    exp_ack = 1'b0;
    c_valid = 1'b0;
  endtask

  task automatic test_zero_wait();
    int lat, s0;
    mem_init[TB_BASE + 26'h100] = 16'h3412;
    mem_init[TB_BASE + 26'h102] = 16'h7856;
    s0 = stab_err;
    run_fetch(21'h100, 0, 1'b0, 1'b0, lat);
    checks++;
    if (rom_data !== 32'h78563412) begin
      failures++; $display("FAIL zero_wait word: got %h expected 78563412", rom_data);
    end
    score_fetch("zero_wait", 21'h100, 0, lat, s0);
  endtask

  task automatic test_wait_states();
    int lat, s0;
    s0 = stab_err;
    run_fetch(21'h2468, 5, 1'b0, 1'b1, lat);
    checks++;
    if (lat !== 13) begin failures++; $display("FAIL wait_states ack cycles: got %0d expected 13", lat); end
    score_fetch("wait_states", 21'h2468, 5, lat, s0);
  endtask

  task automatic test_alignment();
    int lat, s0;
    s0 = stab_err;
    run_fetch(21'h0007, 0, 1'b0, 1'b0, lat);
    checks++;
    if (rd_log.size() != 2 || rd_log[0] !== 26'h200004 || rd_log[1] !== 26'h200006) begin
      failures++;
      $display("FAIL alignment addrs: got %0d reads first %h expected 200004,200006",
               rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 26'h0);
    end
    score_fetch("alignment", 21'h0007, 0, lat, s0);
  endtask

  task automatic test_spurious_ready();
    logic [31:0] d0;
    logic [25:0] a0;
    bit          rd_seen = 1'b0;
    @(negedge clk);
    d0 = rom_data;
    a0 = mem_addr;
    model_en  = 1'b0;
    mem_ready = 1'b1;
    mem_data  = 16'($urandom);
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mem_rd !== 1'b0) rd_seen = 1'b1;
    end
    model_en = 1'b1;
    checks++;
    if (rom_ack !== exp_ack) begin failures++; $display("FAIL spurious rom_ack: got %b expected %b", rom_ack, exp_ack); end
    checks++;
    if (rom_data !== d0) begin failures++; $display("FAIL spurious rom_data: got %h expected %h", rom_data, d0); end
    checks++;
    if (rd_seen) begin failures++; $display("FAIL spurious mem_rd: got 1 expected 0"); end
    checks++;
    if (mem_addr !== a0) begin failures++; $display("FAIL spurious mem_addr: got %h expected %h", mem_addr, a0); end
  endtask

  task automatic test_back_to_back();
    int lat, s0;
    s0 = stab_err;
    run_fetch(21'h1234, 0, 1'b0, 1'b0, lat);
    score_fetch("b2b_first", 21'h1234, 0, lat, s0);
    s0 = stab_err;
    run_fetch(21'h5678, 1, 1'b1, 1'b0, lat);
    score_fetch("b2b_second", 21'h5678, 1, lat, s0);
  endtask

  task automatic test_random();
    int lat, s0, w;
    logic [20:0] a;
    for (int i = 0; i < 10; i++) begin
      a = (i == 0) ? 21'h1FFFFF : 21'($urandom_range(0, 21'h1FFFFF));
      w = $urandom_range(0, 3);
      s0 = stab_err;
      run_fetch(a, w, 1'($urandom_range(0, 1)), 1'b1, lat);
      score_fetch($sformatf("random%0d", i), a, w, lat, s0);
    end
  endtask

  task automatic test_cache();
    int lat, s0;
    s0 = stab_err;
    run_fetch(21'h100, 0, 1'b0, 1'b0, lat);
    score_fetch("cache_prime", 21'h100, 0, lat, s0);
    s0 = stab_err;
    run_fetch(21'h100, 2, 1'b0, 1'b0, lat);
    score_fetch("cache_repeat", 21'h100, 2, lat, s0);
    s0 = stab_err;
    run_fetch(21'h104, 0, 1'b0, 1'b0, lat);
    score_fetch("cache_miss", 21'h104, 0, lat, s0);
  endtask

  task automatic test_reset_mid_fetch();
    int          n;
    logic [25:0] ea;
    ea = exp_ea(21'h0ABC);
    @(negedge clk);
    reset   = 1'b1;
    rom_req = 1'b0;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    exp_ack = 1'b0;
    c_valid = 1'b0;
    @(negedge clk);
    mem_wait    = 2;
    rom_address = 21'h0ABC;
    rom_req     = 1'b1;
    n = 0;
    while (!(mem_rd === 1'b1 && mem_addr === ea + 26'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin failures++; $display("FAIL midreset reach_hi: got timeout expected high read at %h", ea + 26'd2); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_rd !== 1'b0) begin failures++; $display("FAIL midreset mem_rd: got %b expected 0", mem_rd); end
    checks++;
    if (rom_ack !== 1'b0) begin failures++; $display("FAIL midreset rom_ack: got %b expected 0", rom_ack); end
    checks++;
    if (rom_data !== 32'h0) begin failures++; $display("FAIL midreset rom_data: got %h expected 0", rom_data); end
    // Release reset with a stale ready pulse on the bus.
    model_en  = 1'b0;
    reset     = 1'b0;
    mem_ready = 1'b1;
    mem_data  = 16'hDEAD;
    @(negedge clk);
    mem_ready = 1'b0;
    rd_log.delete();
    model_en  = 1'b1;
    n = 0;
    while (rom_ack !== 1'b1 && n < LAT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    exp_ack = 1'b1;
    checks++;
    if (rom_ack !== exp_ack) begin failures++; $display("FAIL midreset reservice ack: got %b expected 1", rom_ack); end
    checks++;
    if (rom_data !== exp_word(ea)) begin
      failures++; $display("FAIL midreset reservice data: got %h expected %h", rom_data, exp_word(ea));
    end
    checks++;
    if (rd_log.size() != 2 || rd_log[0] !== ea || rd_log[1] !== ea + 26'd2) begin
      failures++; $display("FAIL midreset reservice reads: got %0d reads expected 2 at %h", rd_log.size(), ea);
    end
    if (CACHE_EN) begin
      c_valid = 1'b1;
      c_tag   = ea;
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_alignment();
    test_spurious_ready();
    test_back_to_back();
    test_random();
    test_cache();
    test_reset_mid_fetch();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
